// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and helpers for the VGA raster timing generator.
//   - DEF_* : 640x480@60 default segment lengths and sync polarities
//   - axis_total() : total count of one axis (sync + back porch + display + front porch)
//   - cnt_width()  : counter width needed to hold 0..total-1
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // 640x480@60 horizontal timing, in pixels
    localparam int DEF_H_SYNCPULSE = 96;
    localparam int DEF_H_BPORCH    = 48;
    localparam int DEF_H_DISPLAY   = 640;
    localparam int DEF_H_FPORCH    = 16;

    // 640x480@60 vertical timing, in lines
    localparam int DEF_V_SYNCPULSE = 2;
    localparam int DEF_V_BPORCH    = 33;
    localparam int DEF_V_DISPLAY   = 480;
    localparam int DEF_V_FPORCH    = 10;

    // Both syncs are active-low in the 640x480@60 mode
    localparam logic DEF_HSYNC_POL = 1'b0;
    localparam logic DEF_VSYNC_POL = 1'b0;

    localparam int FRAME_CNT_W = 16;

    // Length of one axis period (H_TOTAL or V_TOTAL)
    function automatic int axis_total(input int sync, input int bporch,
                                      input int display, input int fporch);
        return sync + bporch + display + fporch;
    endfunction

    // Bits needed for a counter running 0..total-1 (never less than 1)
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Bundle of raster timing outputs from vga_timing_gen to the DAC sync pins
// and the pixel-fetch logic.
//   master : driven by vga_timing_gen
//   slave  : consumers (DAC, pixel fetch, checkers)
// Signals:
//   hsync, vsync          sync levels (active level set by the generator's POL params)
//   de                    display enable, high inside the visible window
//   pixel_x, pixel_y      visible coordinates, 0 outside the visible window
//   line_start            one-clk pulse when the horizontal counter enters 0
//   frame_start           one-clk pulse when both counters enter (0,0)
//   h_cnt, v_cnt          raw raster counters (debug visibility)
//   h_act, v_act          per-axis active-window flags (debug visibility)
//   frame_cnt             frame counter, present only with VGA_FRAME_CNT_EN
// HC_W / VC_W must equal cnt_width(axis_total(...)) of the generator's axes.
// -----------------------------------------------------------------------------
interface vga_timing_if #(
    parameter int X_W  = 10,
    parameter int Y_W  = 10,
    parameter int HC_W = 10,
    parameter int VC_W = 10
);
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [X_W-1:0]  pixel_x;
    logic [Y_W-1:0]  pixel_y;
    logic            line_start;
    logic            frame_start;
    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic            h_act;
    logic            v_act;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]     frame_cnt;
`endif

    modport master (
        output hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start,
               h_cnt, v_cnt, h_act, v_act
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start,
              h_cnt, v_cnt, h_act, v_act
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a counter running 0..TOTAL-1 with segment order
// sync pulse, back porch, display, front porch (count 0 = first sync cycle).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   enable      advance by one on this clk edge
//   cnt         current count (registered)
//   cnt_nxt     value cnt takes on this edge (combinational)
//   sync        registered sync level, POL while cnt is inside the sync pulse
//   act         registered active-window flag for cnt
//   act_nxt     active-window flag for cnt_nxt (combinational)
//   wrap        high when this edge takes cnt from TOTAL-1 back to 0
// Assumes SYNC >= 1 and DISPLAY >= 1.
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   SYNC    = DEF_H_SYNCPULSE,
    parameter int   BPORCH  = DEF_H_BPORCH,
    parameter int   DISPLAY = DEF_H_DISPLAY,
    parameter int   FPORCH  = DEF_H_FPORCH,
    parameter logic POL     = 1'b0,
    localparam int  TOTAL   = axis_total(SYNC, BPORCH, DISPLAY, FPORCH),
    localparam int  CW      = cnt_width(TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_nxt,
    output logic          sync,
    output logic          act,
    output logic          act_nxt,
    output logic          wrap
);

    // Inclusive segment bounds; using "last" values keeps every constant
    // inside 0..TOTAL-1 so it always fits in CW bits.
    localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC - 1);
    localparam logic [CW-1:0] ACT_FIRST = CW'(SYNC + BPORCH);
    localparam logic [CW-1:0] ACT_LAST  = CW'(SYNC + BPORCH + DISPLAY - 1);

    logic at_last;
    logic sync_nxt;

    assign at_last = (cnt == LAST);
    assign wrap    = enable & at_last;

    always_comb begin
        cnt_nxt = cnt;
        if (enable) begin
            cnt_nxt = at_last ? '0 : cnt + 1'b1;
        end
    end

    // Decode the upcoming count so the registered flags line up with cnt.
    assign act_nxt  = (cnt_nxt >= ACT_FIRST) && (cnt_nxt <= ACT_LAST);
    assign sync_nxt = (cnt_nxt <= SYNC_LAST) ? POL : ~POL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sync <= POL;
            act  <= 1'b0;
        end else if (enable) begin
            cnt  <= cnt_nxt;
            sync <= sync_nxt;
            act  <= act_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator: horizontal and vertical sync, display enable,
// pixel coordinates and line/frame markers, all advanced by a pixel strobe.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   pix_ce  pixel clock enable; state advances only on clk edges with pix_ce=1
//   vid     vga_timing_if.master carrying all timing outputs
// Every output is a register loaded from the counters' next values, so all
// outputs are cycle-aligned with h_cnt/v_cnt. Level outputs hold while
// pix_ce=0; line_start/frame_start drop on the first clk with pix_ce=0, so
// each pulse is exactly one clk wide.
// Optional build macro VGA_FRAME_CNT_EN adds vid.frame_cnt, a 16-bit
// wrapping count of frame_start events.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNCPULSE = DEF_H_SYNCPULSE,
    parameter int   H_BPORCH    = DEF_H_BPORCH,
    parameter int   H_DISPLAY   = DEF_H_DISPLAY,
    parameter int   H_FPORCH    = DEF_H_FPORCH,
    parameter int   V_SYNCPULSE = DEF_V_SYNCPULSE,
    parameter int   V_BPORCH    = DEF_V_BPORCH,
    parameter int   V_DISPLAY   = DEF_V_DISPLAY,
    parameter int   V_FPORCH    = DEF_V_FPORCH,
    parameter logic HSYNC_POL   = DEF_HSYNC_POL,
    parameter logic VSYNC_POL   = DEF_VSYNC_POL,
    parameter int   X_W         = 10,
    parameter int   Y_W         = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    vga_timing_if.master      vid
);

    localparam int H_TOTAL = axis_total(H_SYNCPULSE, H_BPORCH, H_DISPLAY, H_FPORCH);
    localparam int V_TOTAL = axis_total(V_SYNCPULSE, V_BPORCH, V_DISPLAY, V_FPORCH);
    localparam int HC_W    = cnt_width(H_TOTAL);
    localparam int VC_W    = cnt_width(V_TOTAL);

    // Offsets from raw count to visible coordinate
    localparam logic [HC_W-1:0] H_OFF = HC_W'(H_SYNCPULSE + H_BPORCH);
    localparam logic [VC_W-1:0] V_OFF = VC_W'(V_SYNCPULSE + V_BPORCH);

    logic [HC_W-1:0] h_cnt, h_cnt_nxt;
    logic [VC_W-1:0] v_cnt, v_cnt_nxt;
    logic            h_sync, h_act, h_act_nxt, h_wrap;
    logic            v_sync, v_act, v_act_nxt, v_wrap;
    logic            v_en;
    logic            de_nxt;

    logic            de_q;
    logic [X_W-1:0]  pixel_x_q;
    logic [Y_W-1:0]  pixel_y_q;
    logic            line_start_q;
    logic            frame_start_q;

    vga_axis_counter #(
        .SYNC    (H_SYNCPULSE),
        .BPORCH  (H_BPORCH),
        .DISPLAY (H_DISPLAY),
        .FPORCH  (H_FPORCH),
        .POL     (HSYNC_POL)
    ) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (pix_ce),
        .cnt     (h_cnt),
        .cnt_nxt (h_cnt_nxt),
        .sync    (h_sync),
        .act     (h_act),
        .act_nxt (h_act_nxt),
        .wrap    (h_wrap)
    );

    // The vertical axis steps once per line, on the strobe that wraps h_cnt.
    assign v_en = pix_ce & h_wrap;

    vga_axis_counter #(
        .SYNC    (V_SYNCPULSE),
        .BPORCH  (V_BPORCH),
        .DISPLAY (V_DISPLAY),
        .FPORCH  (V_FPORCH),
        .POL     (VSYNC_POL)
    ) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (v_en),
        .cnt     (v_cnt),
        .cnt_nxt (v_cnt_nxt),
        .sync    (v_sync),
        .act     (v_act),
        .act_nxt (v_act_nxt),
        .wrap    (v_wrap)
    );

    assign de_nxt = h_act_nxt & v_act_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q          <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // h_wrap/v_wrap are already qualified by pix_ce, so the markers
            // fall back to 0 on any clk without a strobe.
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (pix_ce) begin
                de_q      <= de_nxt;
                pixel_x_q <= de_nxt ? X_W'(h_cnt_nxt - H_OFF) : '0;
                pixel_y_q <= de_nxt ? Y_W'(v_cnt_nxt - V_OFF) : '0;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign vid.frame_cnt = frame_cnt_q;
`endif

    assign vid.hsync       = h_sync;
    assign vid.vsync       = v_sync;
    assign vid.de          = de_q;
    assign vid.pixel_x     = pixel_x_q;
    assign vid.pixel_y     = pixel_y_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.h_cnt       = h_cnt;
    assign vid.v_cnt       = v_cnt;
    assign vid.h_act       = h_act;
    assign vid.v_act       = v_act;

endmodule
